jtdsp16_ram_ctrl: RTL

- Data-RAM stage directly downstream of the YAAU.
- Consumes the 11-bit RAM address and the read/write strobes from the decoder, and holds the 2K x 16 data memory.
- Returns read data on ram_dout, which feeds the YAAU ram_load path and the data bus.
- Implements compound "exchange" accesses: read the old word and write a new one at the same address, over two cen cycles.

---
 rtl/jtdsp16_pkg.sv | 17 +
 rtl/jtdsp16_ram_mem.sv | 29 ++
 rtl/jtdsp16_ram_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/jtdsp16_pkg.sv
// Shared constants and types for the jtdsp16 data-RAM stage.
// Defining JTDSP16_RAM_PARITY_EN widens each word by one even-parity bit.
package jtdsp16_pkg;

  localparam int RAM_AW = 11;
  localparam int RAM_DW = 16;

  typedef enum logic {
    IDLE = 1'b0,
    XWR  = 1'b1
  } ram_st_t;

  function automatic logic even_par(input logic [RAM_DW-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/jtdsp16_ram_mem.sv
// Single-port synchronous RAM, read and write gated by the clock enable.
// The registered read port keeps its value until the next read.
module jtdsp16_ram_mem #(
  parameter int AW = 11,
  parameter int WW = 16
) (
  input  logic          clk,
  input  logic          cen,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [WW-1:0] wdata,
  output logic [WW-1:0] rdata
);

  logic [WW-1:0] r_mem [2**AW];
  logic [WW-1:0] r_q;

  // Storage carries no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (cen) begin
      if (we) r_mem[addr] <= wdata;
      if (re) r_q <= r_mem[addr];
    end
  end

  assign rdata = r_q;

endmodule

// File: rtl/jtdsp16_ram_ctrl.sv
// Data-RAM controller: reads, writes and two-phase exchange accesses.
// Optional macro JTDSP16_RAM_PARITY_EN adds per-word parity and par_err.
module jtdsp16_ram_ctrl
  import jtdsp16_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = RAM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [AW-1:0] addr,
  input  logic          rd,
  input  logic          wr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] ram_dout,
  output logic          dout_valid,
  output logic          busy,
  output logic          par_err
);

`ifdef JTDSP16_RAM_PARITY_EN
  localparam int WW = DW + 1;
`else
  localparam int WW = DW;
`endif

  ram_st_t       r_st;
  logic [AW-1:0] r_xaddr;
  logic [DW-1:0] r_xdata;
  logic          r_dv;
  logic          r_busy;
  logic          r_ld;

  logic          w_idle;
  logic          w_re;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wd;
  logic [WW-1:0] w_wdata;
  logic [WW-1:0] w_q;

  assign w_idle = (r_st == IDLE);
  assign w_re   = w_idle & rd;
  assign w_we   = w_idle ? (wr & ~rd) : 1'b1;
  assign w_addr = w_idle ? addr : r_xaddr;
  assign w_wd   = w_idle ? din : r_xdata;

`ifdef JTDSP16_RAM_PARITY_EN
  assign w_wdata = {even_par(w_wd), w_wd};
`else
  assign w_wdata = w_wd;
`endif

  jtdsp16_ram_mem #(
    .AW (AW),
    .WW (WW)
  ) u_mem (
    .clk   (clk),
    .cen   (cen),
    .we    (w_we),
    .re    (w_re),
    .addr  (w_addr),
    .wdata (w_wdata),
    .rdata (w_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st    <= IDLE;
      r_xaddr <= '0;
      r_xdata <= '0;
      r_dv    <= 1'b0;
      r_busy  <= 1'b0;
      r_ld    <= 1'b0;
    end else if (cen) begin
      unique case (r_st)
        IDLE: begin
          r_dv <= rd;
          if (rd) r_ld <= 1'b1;
          if (rd & wr) begin
            r_xaddr <= addr;
            r_xdata <= din;
            r_busy  <= 1'b1;
            r_st    <= XWR;
          end
        end
        XWR: begin
          r_dv   <= 1'b0;
          r_busy <= 1'b0;
          r_st   <= IDLE;
        end
      endcase
    end
  end

  // r_ld masks the uninitialised RAM output register until the first read
  assign ram_dout   = r_ld ? w_q[DW-1:0] : '0;
  assign dout_valid = r_dv;
  assign busy       = r_busy;

`ifdef JTDSP16_RAM_PARITY_EN
  assign par_err = r_ld & (w_q[DW] != even_par(w_q[DW-1:0]));
`else
  assign par_err = 1'b0;
`endif

endmodule
